// File: rtl/common.sv
// Shared data-bus payload types and helpers used by the memory stage and its responders.
package common;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {DR_IDLE, DR_WAIT, DR_RESP} dbus_resp_state_t;

  // Request fields the responder keeps while the latency counter runs.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_lat_t;

  // Word offset of a byte address from the mapped base; unsigned, no wrap protection.
  function automatic logic [XLEN-1:0] word_off(input logic [XLEN-1:0] addr,
                                               input logic [XLEN-1:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between the memory stage and a responder.
interface dbus_responder_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dmem_array.sv
// Word-addressed backing store: registered read port and byte-strobed write port, no reset.
module dmem_array #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned WIDTH     = 64,
  localparam int unsigned AW       = $clog2(MEM_WORDS),
  localparam int unsigned BW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [BW-1:0]    wr_strobe,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [MEM_WORDS];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_idx];
    end
    if (wr_en) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (wr_strobe[b]) begin
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by dmem_array; one outstanding request at a time.
module dbus_responder
  import common::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input logic             clk,
  input logic             reset,
  dbus_responder_if.slave bus
);

  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dbus_resp_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbus_req_lat_t    req_q, req_d;
  logic             ok_q, ok_d;
  logic             rd_vld_q, rd_vld_d;

  logic [XLEN-1:0]   look_addr_c;
  logic [STRB_W-1:0] look_strb_c;
  logic              rd_en_c;
  logic              wr_en_c;
  logic [XLEN-1:0]   rd_data_c;
  logic              unused_size_c;

  function automatic logic in_range(input logic [XLEN-1:0] a);
    return (a >= BASE_ADDR) && (word_off(a, BASE_ADDR) < XLEN'(MEM_WORDS));
  endfunction

  // Next-state: capture in IDLE, count down in WAIT (abort on dropped valid), one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      DR_IDLE: begin
        if (bus.dreq.valid) begin
          req_d   = '{addr: bus.dreq.addr, strobe: bus.dreq.strobe, data: bus.dreq.data};
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? DR_RESP : DR_WAIT;
        end
      end
      DR_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (!bus.dreq.valid) begin
          cnt_d   = '0;
          state_d = DR_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DR_RESP;
        end
      end
      DR_RESP: state_d = DR_IDLE;
      default: state_d = DR_IDLE;
    endcase
  end

  // Response flags are registered from the next state so they line up with the RESP cycle.
  always_comb begin
    look_addr_c = (state_q == DR_IDLE) ? bus.dreq.addr   : req_q.addr;
    look_strb_c = (state_q == DR_IDLE) ? bus.dreq.strobe : req_q.strobe;
    ok_d        = (state_d == DR_RESP);
    rd_en_c     = ok_d && (look_strb_c == '0) && in_range(look_addr_c);
    rd_vld_d    = rd_en_c;
    wr_en_c     = (state_q == DR_RESP) && (req_q.strobe != '0) && in_range(req_q.addr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= DR_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      ok_q     <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ok_q     <= ok_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  dmem_array #(
    .MEM_WORDS (MEM_WORDS),
    .WIDTH     (XLEN)
  ) u_mem (
    .clk       (clk),
    .rd_en     (rd_en_c),
    .rd_idx    (AW'(word_off(look_addr_c, BASE_ADDR))),
    .rd_data   (rd_data_c),
    .wr_en     (wr_en_c),
    .wr_idx    (AW'(word_off(req_q.addr, BASE_ADDR))),
    .wr_strobe (req_q.strobe),
    .wr_data   (req_q.data)
  );

  // Read data is only exposed while the registered read-valid flag is set.
  assign bus.dresp = '{addr_ok: ok_q,
                       data_ok: ok_q,
                       data:    rd_vld_q ? rd_data_c : '0};

  assign unused_size_c = ^bus.dreq.size;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder at latencies 2, 4 and 1.
module tb_dbus_responder;
  import common::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dbus_req_t rq1, rq2, rq4;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dbus_responder_if i1 ();
  dbus_responder_if i2 ();
  dbus_responder_if i4 ();
  assign i1.dreq = rq1;
  assign i2.dreq = rq2;
  assign i4.dreq = rq4;

  dbus_responder #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(i1));
  dbus_responder #(.LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(i2));
  dbus_responder #(.LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(i4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
    dbus_req_t r;
    r.valid = v; r.addr = a; r.size = MSIZE8; r.strobe = s; r.data = d;
    case (sel)
      1:       rq1 = r;
      2:       rq2 = r;
      default: rq4 = r;
    endcase
  endtask

  task automatic drop(input int sel);
    case (sel)
      1:       rq1.valid = 1'b0;
      2:       rq2.valid = 1'b0;
      default: rq4.valid = 1'b0;
    endcase
  endtask

  function automatic dbus_resp_t resp_of(input int sel);
    case (sel)
      1:       return i1.dresp;
      2:       return i2.dresp;
      default: return i4.dresp;
    endcase
  endfunction

  // Request already driven; capture edge, latency window, one-cycle pulse, then quiet.
  task automatic complete(input int sel, input int lat, input logic [63:0] exp, input string tag);
    dbus_resp_t r;
    @(posedge clk);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      r = resp_of(sel);
      chk({tag, "/early_ok"}, 64'(r.data_ok), 64'd0);
      @(posedge clk);
    end
    @(negedge clk);
    r = resp_of(sel);
    chk({tag, "/data_ok"}, 64'(r.data_ok), 64'd1);
    chk({tag, "/addr_ok"}, 64'(r.addr_ok), 64'd1);
    chk({tag, "/data"}, r.data, exp);
    drop(sel);
    @(posedge clk);
    @(negedge clk);
    r = resp_of(sel);
    chk({tag, "/after_ok"}, 64'(r.data_ok), 64'd0);
    chk({tag, "/after_data"}, r.data, 64'd0);
  endtask

  task automatic do_req(input int sel, input int lat, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [63:0] exp, input string tag);
    set_req(sel, 1'b1, a, s, d);
    complete(sel, lat, exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dbus_resp_t r;
    set_req(1, 1'b0, 64'h0, 8'h00, 64'h0);
    set_req(4, 1'b0, 64'h0, 8'h00, 64'h0);
    // 1. Reset with a pending full-word write held on the L=2 port
    set_req(2, 1'b1, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      r = resp_of(2);
      chk($sformatf("rst/c%0d_data_ok", c), 64'(r.data_ok), 64'd0);
      chk($sformatf("rst/c%0d_addr_ok", c), 64'(r.addr_ok), 64'd0);
      chk($sformatf("rst/c%0d_data", c), r.data, 64'd0);
    end
    reset = 1'b1;
    // 2. The held write is captured on the first edge after release
    complete(2, 2, 64'd0, "wr_full");
    do_req(2, 2, 64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_5566_7788, "rd_full");
    // 3. Partial write on byte lanes 2 and 3
    do_req(2, 2, 64'h8000_0010, 8'b0000_1100, 64'h0000_0000_AABB_0000, 64'd0, "wr_part");
    do_req(2, 2, 64'h8000_0010, 8'h00, 64'h0, 64'h1122_3344_AABB_7788, "rd_part");
    // 4. Out-of-range accesses on both sides, plus last in-range word
    do_req(2, 2, 64'h8000_0000, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'd0, "wr_w0");
    do_req(2, 2, 64'h7FFF_FFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "wr_below");
    do_req(2, 2, 64'h8000_2000, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, 64'd0, "wr_above");
    do_req(2, 2, 64'h8000_2000, 8'h00, 64'h0, 64'd0, "rd_above");
    do_req(2, 2, 64'h8000_0000, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567, "rd_w0");
    do_req(2, 2, 64'h8000_1FF8, 8'hFF, 64'h0102_0304_0506_0708, 64'd0, "wr_last");
    do_req(2, 2, 64'h8000_1FF8, 8'h00, 64'h0, 64'h0102_0304_0506_0708, "rd_last");
    // 5. Abort at LATENCY=4 in the second WAIT cycle
    do_req(4, 4, 64'h8000_0020, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'd0, "wr_prior");
    set_req(4, 1'b1, 64'h8000_0020, 8'hFF, 64'h5555_5555_5555_5555);
    @(posedge clk);
    @(negedge clk);
    chk("abort/wait1_ok", 64'(i4.dresp.data_ok), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort/wait2_ok", 64'(i4.dresp.data_ok), 64'd0);
    drop(4);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("abort/idle%0d_ok", c), 64'(i4.dresp.data_ok), 64'd0);
    end
    chk("abort/state", 64'(u_l4.state_q), 64'(DR_IDLE));
    do_req(4, 4, 64'h8000_0020, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, "rd_abort");
    // 6. Back-to-back reads at LATENCY=1 with valid held high
    do_req(1, 1, 64'h8000_0100, 8'hFF, 64'h1111_1111_1111_1111, 64'd0, "wr_a");
    do_req(1, 1, 64'h8000_0108, 8'hFF, 64'h2222_2222_2222_2222, 64'd0, "wr_b");
    do_req(1, 1, 64'h8000_0110, 8'hFF, 64'h3333_3333_3333_3333, 64'd0, "wr_c");
    set_req(1, 1'b1, 64'h8000_0100, 8'h00, 64'h0);
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      r = resp_of(1);
      chk($sformatf("b2b/c%0d_ok", c), 64'(r.data_ok), 64'(c == 1 || c == 3 || c == 5));
      if (c == 1) begin
        chk("b2b/data_a", r.data, 64'h1111_1111_1111_1111);
        set_req(1, 1'b1, 64'h8000_0108, 8'h00, 64'h0);
      end else if (c == 3) begin
        chk("b2b/data_b", r.data, 64'h2222_2222_2222_2222);
        set_req(1, 1'b1, 64'h8000_0110, 8'h00, 64'h0);
      end else if (c == 5) begin
        chk("b2b/data_c", r.data, 64'h3333_3333_3333_3333);
        drop(1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
